// File: rtl/tmds_rx_pkg.sv
// tmds_rx_pkg: TMDS control tokens, aligner states and the token matcher shared with the decoder
package tmds_rx_pkg;
  localparam logic [9:0] CTRL_TOK0 = 10'h354;
  localparam logic [9:0] CTRL_TOK1 = 10'h0AB;
  localparam logic [9:0] CTRL_TOK2 = 10'h154;
  localparam logic [9:0] CTRL_TOK3 = 10'h2AB;
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} align_state_e;
  function automatic logic is_ctrl_token(input logic [9:0] w);
    return (w == CTRL_TOK0) || (w == CTRL_TOK1) || (w == CTRL_TOK2) || (w == CTRL_TOK3);
  endfunction
endpackage

// File: rtl/tmds_rx_lane_align_if.sv
// tmds_rx_lane_align_if: DDR bit pair in, aligned TMDS word and alignment status out
interface tmds_rx_lane_align_if;
  logic       rx_h;
  logic       rx_l;
  logic [9:0] word_out;
  logic       word_valid;
  logic       ctrl_token;
  logic       locked;
  logic [3:0] slip_ofs;
  modport master (output rx_h, rx_l, input word_out, word_valid, ctrl_token, locked, slip_ofs);
  modport slave (input rx_h, rx_l, output word_out, word_valid, ctrl_token, locked, slip_ofs);
endinterface

// File: rtl/tmds_rx_gearbox_2to10.sv
// tmds_rx_gearbox_2to10: 2-bit to 10-bit deserializer with a bit-offset window over a 20-bit history
module tmds_rx_gearbox_2to10 (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_h,
  input  logic       rx_l,
  input  logic [3:0] ofs,
  output logic       cap,
  output logic [9:0] win,
  output logic [9:0] word_out,
  output logic       word_valid
);
  logic [19:0] sr_q, sr_d;
  logic [2:0]  phase_q, phase_d;
  logic [9:0]  word_out_q, word_out_d;
  logic        word_valid_q, word_valid_d;
  always_comb begin
    cap = phase_q == 3'd4;
    win = 10'(sr_q >> ofs);
    sr_d = {rx_l, rx_h, sr_q[19:2]};
    phase_d = cap ? 3'd0 : phase_q + 3'd1;
    word_out_d = cap ? win : word_out_q;
    word_valid_d = cap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
      phase_q <= '0;
      word_out_q <= '0;
      word_valid_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      phase_q <= phase_d;
      word_out_q <= word_out_d;
      word_valid_q <= word_valid_d;
    end
  end
  assign word_out = word_out_q;
  assign word_valid = word_valid_q;
endmodule

// File: rtl/tmds_rx_lane_align.sv
// tmds_rx_lane_align: one TMDS lane deserializer plus control-token word aligner
module tmds_rx_lane_align
  import tmds_rx_pkg::*;
#(
  parameter int LOCK_TOKENS  = 8,
  parameter int SEARCH_WORDS = 16,
  parameter int LOSS_WORDS   = 65536,
  parameter int CNT_W        = 17
) (
  input logic clk,
  input logic rst,
  tmds_rx_lane_align_if.slave lane
);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(LOCK_TOKENS);
  localparam logic [CNT_W-1:0] WC_MAX  = CNT_W'(SEARCH_WORDS - 1);
  localparam logic [CNT_W-1:0] LC_MAX  = CNT_W'(LOSS_WORDS - 1);
  align_state_e     state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d, run_q, run_d, lcnt_q, lcnt_d, run_inc;
  logic [3:0]       ofs_q, ofs_d;
  logic             locked_q, locked_d, ctrl_q, ctrl_d, cap, tok;
  logic [9:0]       win;
  tmds_rx_gearbox_2to10 u_gearbox (
    .clk        (clk),
    .rst        (rst),
    .rx_h       (lane.rx_h),
    .rx_l       (lane.rx_l),
    .ofs        (ofs_q),
    .cap        (cap),
    .win        (win),
    .word_out   (lane.word_out),
    .word_valid (lane.word_valid)
  );
  always_comb begin
    tok = is_ctrl_token(win);
    run_inc = (run_q == RUN_MAX) ? run_q : run_q + ONE;
    state_d = state_q;
    wcnt_d = wcnt_q;
    run_d = run_q;
    lcnt_d = lcnt_q;
    ofs_d = ofs_q;
    locked_d = locked_q;
    ctrl_d = cap ? tok : ctrl_q;
    if (cap)
      case (state_q)
        SEARCH:
          if (tok) begin
            state_d = VERIFY;
            run_d = ONE;
          end else begin
            wcnt_d = (wcnt_q == WC_MAX) ? '0 : wcnt_q + ONE;
            ofs_d = (wcnt_q != WC_MAX) ? ofs_q : (ofs_q == 4'd9) ? 4'd0 : ofs_q + 4'd1;
          end
        VERIFY:
          if (!tok) begin
            state_d = SEARCH;
            wcnt_d = '0;
          end else begin
            run_d = run_inc;
            if (run_inc == RUN_MAX) begin
              state_d = LOCKED;
              locked_d = 1'b1;
              lcnt_d = '0;
            end
          end
        default: begin
          run_d = tok ? run_inc : '0;
          lcnt_d = (run_d == RUN_MAX) ? '0 : lcnt_q + ONE;
          // a full token run in the same word as the timeout keeps the lock
          if (run_d != RUN_MAX && lcnt_q == LC_MAX) begin
            state_d = SEARCH;
            locked_d = 1'b0;
            wcnt_d = '0;
            run_d = '0;
            lcnt_d = '0;
          end
        end
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      wcnt_q <= '0;
      run_q <= '0;
      lcnt_q <= '0;
      ofs_q <= '0;
      locked_q <= 1'b0;
      ctrl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      run_q <= run_d;
      lcnt_q <= lcnt_d;
      ofs_q <= ofs_d;
      locked_q <= locked_d;
      ctrl_q <= ctrl_d;
    end
  end
  assign lane.ctrl_token = ctrl_q;
  assign lane.locked = locked_q;
  assign lane.slip_ofs = ofs_q;
endmodule

// File: tb/tb_tmds_rx_lane_align.sv
// tb_tmds_rx_lane_align: directed alignment scenarios and randomized loopback against a bit-history model
module tb_tmds_rx_lane_align;
  localparam int LT = 8, SW = 16, LW = 200, CW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0, n_bad = 0;
  logic bq[$];
  logic txq[$];
  logic [9:0] txw[$];
  int e, ncap, lag, m_mode, m_wc, m_run, m_lc, m_ofs;
  logic m_lock;

  tmds_rx_lane_align_if lane ();
  tmds_rx_lane_align #(.LOCK_TOKENS(LT), .SEARCH_WORDS(SW), .LOSS_WORDS(LW), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .lane (lane.slave)
  );
  always #5 clk = ~clk;

  function automatic logic is_tok(input logic [9:0] w);
    return w == 10'h354 || w == 10'h0AB || w == 10'h154 || w == 10'h2AB;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    do w = 10'($urandom_range(0, 1023)); while (is_tok(w));
    return w;
  endfunction

  function automatic logic [9:0] rand_tok();
    int k;
    k = $urandom_range(0, 3);
    return k == 0 ? 10'h354 : k == 1 ? 10'h0AB : k == 2 ? 10'h154 : 10'h2AB;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // alignment rules: 0 hunting, 1 confirming a token run, 2 locked
  task automatic model_word(input logic tk);
    if (m_mode == 0) begin
      if (tk) begin
        m_mode = 1;
        m_run = 1;
      end else if (m_wc == SW - 1) begin
        m_wc = 0;
        m_ofs = (m_ofs + 1) % 10;
      end else m_wc++;
    end else if (m_mode == 1) begin
      if (!tk) begin
        m_mode = 0;
        m_wc = 0;
      end else begin
        m_run++;
        if (m_run == LT) begin
          m_mode = 2;
          m_lock = 1'b1;
          m_lc = 0;
        end
      end
    end else begin
      m_run = tk ? ((m_run < LT) ? m_run + 1 : LT) : 0;
      if (m_run == LT) m_lc = 0;
      else if (m_lc == LW - 1) begin
        m_mode = 0;
        m_lock = 1'b0;
        m_wc = 0;
        m_run = 0;
        m_lc = 0;
      end else m_lc++;
    end
  endtask

  task automatic step();
    logic h, l, cap, tk, lb;
    logic [9:0] w, tw;
    h = txq.pop_front();
    l = txq.pop_front();
    lane.rx_h = h;
    lane.rx_l = l;
    cap = (e % 5 == 4);
    w = '0;
    tw = '0;
    tk = 1'b0;
    lb = 1'b0;
    if (cap) begin
      for (int i = 0; i < 10; i++)
        if (2 * e - 20 + m_ofs + i >= 0) w[i] = bq[2 * e - 20 + m_ofs + i];
      tk = is_tok(w);
      lb = m_lock && lag >= 0 && ncap >= lag && ncap - lag < txw.size();
      if (lb) tw = txw[ncap - lag];
      model_word(tk);
      ncap++;
    end
    @(posedge clk);
    bq.push_back(h);
    bq.push_back(l);
    e++;
    #1;
    chk("word_valid", 16'(lane.word_valid), 16'(cap));
    if (cap) begin
      chk("word_out", 16'(lane.word_out), 16'(w));
      chk("ctrl_token", 16'(lane.ctrl_token), 16'(tk));
    end
    if (lb) chk("loopback", 16'(lane.word_out), 16'(tw));
    chk("locked", 16'(lane.locked), 16'(m_lock));
    chk("slip_ofs", 16'(lane.slip_ofs), 16'(m_ofs));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lane.rx_h = 1'b0;
    lane.rx_l = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_word_out", 16'(lane.word_out), 16'h0);
    chk("rst_word_valid", 16'(lane.word_valid), 16'h0);
    chk("rst_ctrl_token", 16'(lane.ctrl_token), 16'h0);
    chk("rst_locked", 16'(lane.locked), 16'h0);
    chk("rst_slip_ofs", 16'(lane.slip_ofs), 16'h0);
    rst = 1'b0;
    bq.delete();
    txq.delete();
    txw.delete();
    e = 0;
    ncap = 0;
    lag = -1;
    m_mode = 0;
    m_wc = 0;
    m_run = 0;
    m_lc = 0;
    m_ofs = 0;
    m_lock = 1'b0;
  endtask

  // a prefix of (8+d)%10 zero bits puts word boundaries at bit offset d of the window
  task automatic start(input int d);
    do_reset();
    repeat ((8 + d) % 10) txq.push_back(1'b0);
  endtask

  task automatic send(input logic [9:0] w);
    for (int i = 0; i < 10; i++) txq.push_back(w[i]);
    txw.push_back(w);
    while (txq.size() >= 2) step();
  endtask

  initial begin
    int k, d;
    lane.rx_h = 1'b0;
    lane.rx_l = 1'b0;
    lag = -1;
    repeat (2) @(posedge clk);
    start(0);
    repeat (12) send(10'h000);
    chk("idle_locked", 16'(lane.locked), 16'h0);
    chk("idle_ctrl", 16'(lane.ctrl_token), 16'h0);
    start(3);
    repeat (70) send(10'h354);
    chk("ofs3_locked", 16'(lane.locked), 16'h1);
    chk("ofs3_slip", 16'(lane.slip_ofs), 16'h3);
    chk("ofs3_word", 16'(lane.word_out), 16'h354);
    chk("ofs3_ctrl", 16'(lane.ctrl_token), 16'h1);
    start(9);
    repeat (170) send(10'h354);
    chk("ofs9_locked", 16'(lane.locked), 16'h1);
    chk("ofs9_slip", 16'(lane.slip_ofs), 16'h9);
    start(0);
    repeat (150) send(10'h000);
    chk("wrap_pre", 16'(lane.slip_ofs), 16'h9);
    repeat (18) send(10'h000);
    chk("wrap_post", 16'(lane.slip_ofs), 16'h0);
    chk("wrap_locked", 16'(lane.locked), 16'h0);
    start(0);
    repeat (5) send(10'h354);
    repeat (3) send(10'h1F0);
    chk("verify_break_locked", 16'(lane.locked), 16'h0);
    chk("verify_break_ofs", 16'(lane.slip_ofs), 16'h0);
    repeat (14) send(10'h354);
    chk("relock_ofs0", 16'(lane.locked), 16'h1);
    send(10'h1F0);
    repeat (5) send(10'h354);
    send(10'h1F0);
    repeat (3) send(rand_data());
    chk("locked_break_kept", 16'(lane.locked), 16'h1);
    start(4);
    repeat (90) send(10'h354);
    chk("ofs4_locked", 16'(lane.locked), 16'h1);
    chk("ofs4_slip", 16'(lane.slip_ofs), 16'h4);
    repeat (LW - 5) send(10'h1F0);
    chk("loss_pre", 16'(lane.locked), 16'h1);
    repeat (7) send(10'h1F0);
    chk("loss_post", 16'(lane.locked), 16'h0);
    chk("loss_ofs_kept", 16'(lane.slip_ofs), 16'h4);
    repeat (12) send(10'h354);
    chk("loss_relock", 16'(lane.locked), 16'h1);
    chk("loss_relock_ofs", 16'(lane.slip_ofs), 16'h4);
    do_reset();
    k = 0;
    while (!lane.word_valid && k < 10) begin
      txq.push_back(1'b0);
      txq.push_back(1'b0);
      step();
      k++;
    end
    chk("phase_restart", 16'(k), 16'd5);
    d = $urandom_range(0, 9);
    start(d);
    lag = ((8 + d) % 10 - d + 12) / 10;
    repeat (40) begin
      repeat (12) send(rand_tok());
      repeat (29) send(rand_data());
    end
    chk("loop_locked", 16'(lane.locked), 16'h1);
    chk("loop_ofs", 16'(lane.slip_ofs), 16'(d));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
